// File: rtl/life_pixel_renderer.sv
// life_pixel_renderer
//   Two-stage video pipeline that draws a Game-of-Life board as 8x8 icons
//   inside a fixed window. It also counts the live cells seen during each
//   frame.
//
// Ports
//   clk, rst_n           pixel clock; synchronous active-low reset
//   hsync_in, vsync_in   raw syncs from the timing generator
//   display_on           visible-area flag
//   hpos, vpos           current pixel coordinates
//   color_sel            live-cell palette select
//   cell_addr            board read address {row, col}, combinational
//   cell_data            board cell state, valid one cycle after cell_addr
//   hsync, vsync         syncs delayed by two cycles
//   r, g, b              2-bit colour outputs, two cycles after the inputs
//   population           live-cell count of the last complete frame
//   pop_valid            one-cycle strobe when population updates
module life_pixel_renderer #(
  parameter int unsigned X_ORIGIN = 64,
  parameter int unsigned Y_ORIGIN = 112,
  parameter int unsigned LOG_W    = 6,
  parameter int unsigned LOG_H    = 5,
  parameter int unsigned CELL_LOG = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     display_on,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic [1:0]               color_sel,
  output logic [LOG_W+LOG_H-1:0]   cell_addr,
  input  logic                     cell_data,
  output logic                     hsync,
  output logic                     vsync,
  output logic [1:0]               r,
  output logic [1:0]               g,
  output logic [1:0]               b,
  output logic [LOG_W+LOG_H:0]     population,
  output logic                     pop_valid
);

  localparam int unsigned POP_W = LOG_W + LOG_H + 1;
  localparam logic [10:0] X0    = 11'(X_ORIGIN);
  localparam logic [10:0] Y0    = 11'(Y_ORIGIN);
  localparam logic [10:0] WIN_W = 11'(1 << (LOG_W + CELL_LOG));
  localparam logic [10:0] WIN_H = 11'(1 << (LOG_H + CELL_LOG));

  // Window decode and board address
  logic [10:0] hx, vy;
  logic        in_win;
  logic        first_px;

  // Compute offsets one bit wider than the inputs, so that a coordinate
  // left of or above the origin fails the range test instead of wrapping
  // into the window.
  always_comb begin
    hx       = {1'b0, hpos} - X0;
    vy       = {1'b0, vpos} - Y0;
    in_win   = ({1'b0, hpos} >= X0) && (hx < WIN_W) &&
               ({1'b0, vpos} >= Y0) && (vy < WIN_H);
    first_px = in_win && (hpos[CELL_LOG-1:0] == '0) && (vpos[CELL_LOG-1:0] == '0);
    cell_addr = {vy[CELL_LOG +: LOG_H], hx[CELL_LOG +: LOG_W]};
  end

  // Stage 1 is plain registers with no reset.
  logic       win_q, de_q, hs_q, vs_q, first_q;
  logic [2:0] hpix_q, vpix_q;
  logic [1:0] sel_q;

  always_ff @(posedge clk) begin
    win_q   <= in_win;
    de_q    <= display_on;
    hs_q    <= hsync_in;
    vs_q    <= vsync_in;
    hpix_q  <= hpos[2:0];
    vpix_q  <= vpos[2:0];
    first_q <= first_px;
    sel_q   <= color_sel;
  end

  // Stage 2: icon lookup and colour selection
  logic [7:0] icon_row;
  logic       icon_bit;
  logic [5:0] rgb_d;

  always_comb begin
    icon_row = '0;
    case (vpix_q)
      3'd1, 3'd6:             icon_row = 8'h3C;
      3'd2, 3'd3, 3'd4, 3'd5: icon_row = 8'h7E;
      default:                icon_row = 8'h00;
    endcase
    icon_bit = icon_row[hpix_q];
  end

  always_comb begin
    rgb_d = '0;
    if (!de_q || !win_q) begin
      rgb_d = '0;
    end else if (cell_data && icon_bit) begin
      case (sel_q)
        2'd0:    rgb_d = 6'b11_11_01;
        2'd1:    rgb_d = 6'b00_11_00;
        2'd2:    rgb_d = 6'b11_00_00;
        default: rgb_d = 6'b11_11_11;
      endcase
    end else begin
      rgb_d = 6'b00_00_01;
    end
  end

  // Population counting
  logic [POP_W-1:0] acc_q, acc_d;
  logic [POP_W-1:0] pop_q;
  logic             pop_valid_q;
  logic             vs_prev_q;
  logic             frame_edge;
  logic [5:0]       rgb_q;
  logic             hsync_q, vsync_q;

  always_comb begin
    acc_d      = acc_q + POP_W'(first_q & cell_data);
    frame_edge = vs_q & ~vs_prev_q;
  end

  // vs_prev_q resets to 1. If reset is released while vsync is high, that
  // level is not treated as a new frame edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      acc_q       <= '0;
      pop_q       <= '0;
      pop_valid_q <= 1'b0;
      vs_prev_q   <= 1'b1;
    end else begin
      rgb_q     <= rgb_d;
      hsync_q   <= hs_q;
      vsync_q   <= vs_q;
      vs_prev_q <= vs_q;
      if (frame_edge) begin
        // A corner pixel counted in the edge cycle still belongs to the
        // frame that is ending.
        pop_q       <= acc_d;
        pop_valid_q <= 1'b1;
        acc_q       <= '0;
      end else begin
        pop_valid_q <= 1'b0;
        acc_q       <= acc_d;
      end
    end
  end

  assign {r, g, b}  = rgb_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign population = pop_q;
  assign pop_valid  = pop_valid_q;

endmodule

// File: tb/tb_life_pixel_renderer.sv
module tb_life_pixel_renderer;

  localparam int XO = 64;
  localparam int YO = 112;

  typedef struct packed {
    logic [5:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsync_in, vsync_in, display_on;
  logic [9:0]  hpos, vpos;
  logic [1:0]  color_sel;
  logic [10:0] cell_addr;
  logic        cell_data = 1'b0;
  logic        hsync, vsync;
  logic [1:0]  r, g, b;
  logic [11:0] population;
  logic        pop_valid;

  bit          board [2048];
  int          passed = 0;
  int          total  = 0;
  int          pv_count = 0;
  logic [11:0] pv_value = '0;
  exp_t        exp_q[$];

  life_pixel_renderer #(
    .X_ORIGIN(64), .Y_ORIGIN(112), .LOG_W(6), .LOG_H(5), .CELL_LOG(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .color_sel(color_sel),
    .cell_addr(cell_addr), .cell_data(cell_data), .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b), .population(population), .pop_valid(pop_valid)
  );

  always #5 clk = ~clk;

  // Board memory with a one-cycle read
  always @(posedge clk) cell_data <= board[cell_addr];

  // Reference model
  function automatic bit icon_on(input int x, input int y);
    if (y == 1 || y == 6) return (x >= 2 && x <= 5);
    if (y >= 2 && y <= 5) return (x >= 1 && x <= 6);
    return 1'b0;
  endfunction

  function automatic logic [5:0] exp_px(input int h, input int v, input bit de, input int sel);
    int idx;
    if (!de) return 6'b0;
    if (h < XO || h >= XO + 512 || v < YO || v >= YO + 256) return 6'b0;
    idx = ((v - YO) / 8) * 64 + (h - XO) / 8;
    if (board[idx] && icon_on(h % 8, v % 8)) begin
      case (sel)
        0:       return 6'b111101;
        1:       return 6'b001100;
        2:       return 6'b110000;
        default: return 6'b111111;
      endcase
    end
    return 6'b000001;
  endfunction

  // Apply one cycle of inputs, advance past the edge, and note any pop strobe
  task automatic drive(input int h, input int v, input bit de, input bit hs, input bit vs);
    hpos = h[9:0]; vpos = v[9:0]; display_on = de; hsync_in = hs; vsync_in = vs;
    @(posedge clk); #1;
    if (pop_valid) begin
      pv_count++;
      pv_value = population;
    end
  endtask

  task automatic scan_rows(input int v0, input int v1);
    for (int v = v0; v < v1; v += 8)
      for (int h = 0; h < 640; h += 4)
        drive(h, v, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic clear_board();
    for (int i = 0; i < 2048; i++) board[i] = 1'b0;
  endtask

  task automatic frame_flush();
    drive(0, 0, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b0, 1'b1);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    pv_count = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    clear_board();
    board[0] = 1'b1;
    color_sel = 2'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(XO + 3, YO + 3, 1'b1, 1'b1, 1'b1);
      total++;
      if ({r, g, b, hsync, vsync, pop_valid} !== 9'b0 || population !== 12'd0) begin
        $display("FAIL reset_outputs got rgb=%b hs=%b vs=%b pv=%b pop=%0d expected all zero",
                 {r, g, b}, hsync, vsync, pop_valid, population);
      end else passed++;
    end
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.rgb = exp_px(XO + 3, YO + 3, 1'b1, 0); e.hs = 1'b0; e.vs = 1'b0;
      exp_q.push_back(e);
      drive(XO + 3, YO + 3, 1'b1, 1'b0, 1'b0);
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb || hsync !== e.hs || vsync !== e.vs)
          $display("FAIL post_reset_pixel got rgb=%b hs=%b vs=%b expected rgb=%b hs=%b vs=%b",
                   {r, g, b}, hsync, vsync, e.rgb, e.hs, e.vs);
        else passed++;
      end
    end
  endtask

  task automatic test_pixel_path();
    exp_t e;
    int hs_t[4] = '{XO, XO + 3, 600, 600};
    int vs_t[4] = '{YO, YO + 3, 10, 10};
    clear_board();
    board[0] = 1'b1;
    color_sel = 2'd0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      e.rgb = exp_px(hs_t[i], vs_t[i], 1'b1, 0); e.hs = 1'b0; e.vs = 1'b0;
      exp_q.push_back(e);
      drive(hs_t[i], vs_t[i], 1'b1, 1'b0, 1'b0);
      if (i < 2) begin
        total++;
        if (cell_addr !== 11'd0) $display("FAIL pixel_addr got %0d expected 0", cell_addr);
        else passed++;
      end
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb) $display("FAIL pixel_rgb got %b expected %b", {r, g, b}, e.rgb);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int hs_t[5] = '{XO + 511, XO + 512, XO - 1, 0, 0};
    int vs_t[5] = '{YO + 255, YO + 255, YO + 255, 0, 0};
    clear_board();
    board[2047] = 1'b1;
    board[2046] = 1'b1;
    color_sel = 2'd3;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      e.rgb = exp_px(hs_t[i], vs_t[i], 1'b1, 3); e.hs = 1'b0; e.vs = 1'b0;
      exp_q.push_back(e);
      drive(hs_t[i], vs_t[i], 1'b1, 1'b0, 1'b0);
      if (i == 0) begin
        total++;
        if (cell_addr !== 11'd2047) $display("FAIL wrap_addr got %0d expected 2047", cell_addr);
        else passed++;
      end
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb) $display("FAIL wrap_rgb got %b expected %b", {r, g, b}, e.rgb);
        else passed++;
      end
    end
  endtask

  task automatic test_blanking();
    exp_t e;
    bit hs_p[10] = '{0, 1, 1, 1, 0, 0, 1, 0, 0, 0};
    bit de_p[10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 1};
    clear_board();
    board[0] = 1'b1;
    color_sel = 2'd0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      e.rgb = exp_px(XO + 3, YO + 3, de_p[i], 0); e.hs = hs_p[i]; e.vs = 1'b0;
      exp_q.push_back(e);
      drive(XO + 3, YO + 3, de_p[i], hs_p[i], 1'b0);
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb || hsync !== e.hs || vsync !== e.vs)
          $display("FAIL blank_hsync got rgb=%b hs=%b vs=%b expected rgb=%b hs=%b vs=%b",
                   {r, g, b}, hsync, vsync, e.rgb, e.hs, e.vs);
        else passed++;
      end
    end
  endtask

  task automatic test_palette();
    exp_t e;
    clear_board();
    board[0] = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 14; i++) begin
      color_sel = 2'((i / 3) % 4);
      e.rgb = exp_px(XO + 4, YO + 4, 1'b1, (i / 3) % 4); e.hs = 1'b0; e.vs = 1'b0;
      exp_q.push_back(e);
      drive(XO + 4, YO + 4, 1'b1, 1'b0, 1'b0);
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb) $display("FAIL palette_rgb got %b expected %b", {r, g, b}, e.rgb);
        else passed++;
      end
    end
  endtask

  task automatic test_random_pixels();
    exp_t e;
    int h, v, sel;
    bit de, hs, vs;
    for (int i = 0; i < 2048; i++) board[i] = ($urandom_range(0, 2) == 0);
    exp_q.delete();
    for (int i = 0; i < 300; i++) begin
      h   = (i % 3 == 0) ? int'($urandom_range(0, 639)) : XO + int'($urandom_range(0, 511));
      v   = (i % 3 == 0) ? int'($urandom_range(0, 479)) : YO + int'($urandom_range(0, 255));
      de  = ($urandom_range(0, 5) != 0);
      hs  = $urandom_range(0, 1);
      vs  = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      color_sel = 2'(sel);
      e.rgb = exp_px(h, v, de, sel); e.hs = hs; e.vs = vs;
      exp_q.push_back(e);
      drive(h, v, de, hs, vs);
      if (exp_q.size() >= 2) begin
        e = exp_q.pop_front();
        total++;
        if ({r, g, b} !== e.rgb || hsync !== e.hs || vsync !== e.vs)
          $display("FAIL random_px got rgb=%b hs=%b vs=%b expected rgb=%b hs=%b vs=%b",
                   {r, g, b}, hsync, vsync, e.rgb, e.hs, e.vs);
        else passed++;
      end
    end
  endtask

  task automatic test_simultaneous();
    clear_board();
    board[0] = 1'b1; board[1] = 1'b1; board[2] = 1'b1;
    frame_flush();
    drive(XO, YO, 1'b1, 1'b0, 1'b0);
    drive(XO + 8, YO, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_count !== 1 || pv_value !== 12'd2)
      $display("FAIL simul_edge got strobes=%0d pop=%0d expected strobes=1 pop=2", pv_count, pv_value);
    else passed++;
    pv_count = 0;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(XO + 16, YO, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_count !== 1 || pv_value !== 12'd1)
      $display("FAIL simul_next got strobes=%0d pop=%0d expected strobes=1 pop=1", pv_count, pv_value);
    else passed++;
  endtask

  task automatic test_population();
    int n, idx, expct;
    clear_board();
    n = 0;
    while (n < 5) begin
      idx = $urandom_range(0, 2047);
      if (!board[idx]) begin board[idx] = 1'b1; n++; end
    end
    expct = 0;
    for (int i = 0; i < 2048; i++) expct += board[i];
    frame_flush();
    scan_rows(0, 480);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    total++;
    if (pv_count !== 0) $display("FAIL pop_no_early got strobes=%0d expected 0", pv_count);
    else passed++;
    // vsync is held high for many cycles so that only one strobe is expected
    for (int i = 0; i < 20; i++) drive(0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_count !== 1 || pv_value !== 12'(expct))
      $display("FAIL pop_frame1 got strobes=%0d pop=%0d expected strobes=1 pop=%0d", pv_count, pv_value, expct);
    else passed++;
    total++;
    if (population !== 12'(expct))
      $display("FAIL pop_hold got %0d expected %0d", population, expct);
    else passed++;
    clear_board();
    pv_count = 0;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    scan_rows(0, 480);
    for (int i = 0; i < 5; i++) drive(0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_count !== 1 || pv_value !== 12'd0)
      $display("FAIL pop_frame2 got strobes=%0d pop=%0d expected strobes=1 pop=0", pv_count, pv_value);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int n, idx, expct;
    clear_board();
    n = 0;
    while (n < 3) begin
      idx = $urandom_range(0, 1023);
      if (!board[idx]) begin board[idx] = 1'b1; n++; end
    end
    n = 0;
    while (n < 2) begin
      idx = $urandom_range(1024, 2047);
      if (!board[idx]) begin board[idx] = 1'b1; n++; end
    end
    // Only the lower half of the board is scanned after the reset.
    expct = 0;
    for (int i = 1024; i < 2048; i++) expct += board[i];
    frame_flush();
    scan_rows(0, 240);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1'b1, 1'b0, 1'b1);
      total++;
      if (pop_valid !== 1'b0 || population !== 12'd0)
        $display("FAIL midreset_hold got pv=%b pop=%0d expected pv=0 pop=0", pop_valid, population);
      else passed++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1'b1, 1'b0, 1'b1);
      total++;
      if (pop_valid !== 1'b0)
        $display("FAIL release_vsync_high got pv=%b expected 0", pop_valid);
      else passed++;
    end
    pv_count = 0;
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    scan_rows(240, 480);
    drive(0, 0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1'b1, 1'b0, 1'b1);
    total++;
    if (pv_count !== 1 || pv_value !== 12'(expct))
      $display("FAIL midreset_pop got strobes=%0d pop=%0d expected strobes=1 pop=%0d", pv_count, pv_value, expct);
    else passed++;
  endtask

  initial begin
    rst_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; display_on = 1'b0;
    hpos = '0; vpos = '0; color_sel = '0;
    test_reset();
    test_pixel_path();
    test_wrap();
    test_blanking();
    test_palette();
    test_random_pixels();
    test_simultaneous();
    test_population();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
